// File: rtl/mac_share_ctrl.sv
// Round-robin scheduler for a shared add/multiply pipeline.
// In-flight ops are tagged and results land in a credit-guarded response FIFO.
module mac_share_ctrl #(
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic        req1_ready,
  output logic [7:0]  dp_a,
  output logic [7:0]  dp_b,
  output logic        dp_valid,
  input  logic [7:0]  dp_s1,
  input  logic [15:0] dp_s2,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [7:0]  rsp_s1,
  output logic [15:0] rsp_s2,
  input  logic        rsp_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] credits;
  logic          rr;
  logic          allow;
  logic          gnt0;
  logic          gnt1;
  logic          issue;
  logic          pop;
  logic          push;
  logic          full;
  logic          dp_id;
  logic [LAT-1:0] tv;
  logic [LAT-1:0] tid;
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [24:0]   mem [DEPTH];
  logic [24:0]   head;

  // Credits cover in-flight ops plus FIFO entries, so a push never overflows.
  assign allow = credits < CW'(DEPTH);

  assign gnt0 = reset & allow & req0_valid
              & (~req1_valid | ~rr);
  assign gnt1 = reset & allow & req1_valid
              & (~req0_valid | rr);

  assign issue      = gnt0 | gnt1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credits  <= '0;
      rr       <= 1'b0;
      dp_valid <= 1'b0;
      dp_a     <= '0;
      dp_b     <= '0;
      dp_id    <= 1'b0;
    end else begin
      credits  <= credits + CW'(issue) - CW'(pop);
      dp_valid <= issue;
      if (issue) begin
        rr    <= gnt0;
        dp_id <= gnt1;
        dp_a  <= gnt1 ? req1_a : req0_a;
        dp_b  <= gnt1 ? req1_b : req0_b;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tv  <= '0;
      tid <= '0;
    end else begin
      tv[0]  <= dp_valid;
      tid[0] <= dp_id;
      for (int i = 1; i < LAT; i++) begin
        tv[i]  <= tv[i-1];
        tid[i] <= tid[i-1];
      end
    end
  end

  assign push = tv[LAT-1];
  assign pop  = rsp_valid & rsp_ready;
  assign full = (wp[PW-1] != rp[PW-1])
              && (wp[AW-1:0] == rp[AW-1:0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop)           rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wp[AW-1:0]] <= {tid[LAT-1], dp_s1, dp_s2};
  end

  // Head fields are masked so the outputs read zero whenever empty.
  assign head      = mem[rp[AW-1:0]];
  assign rsp_valid = wp != rp;
  assign rsp_id    = rsp_valid & head[24];
  assign rsp_s1    = rsp_valid ? head[23:16] : '0;
  assign rsp_s2    = rsp_valid ? head[15:0] : '0;

endmodule
